// File: rtl/runner_pkg.sv
// Shared definitions for the runner game controller.
// Holds the state encoding seen on the state output and the default
// widths/limits used when the controller is instantiated without overrides.
package runner_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    READY  = 3'd1,
    RUN    = 3'd2,
    PAUSED = 3'd3,
    OVER   = 3'd4
  } state_e;

  localparam int DEF_SEC_W       = 8;
  localparam int DEF_MAX_SECONDS = 99;
  localparam int DEF_COUNTDOWN   = 3;

endpackage

// File: rtl/runner_game_ctrl_if.sv
// Signal bundle between the game controller and its surroundings.
// Inputs: start_sw, pause_sw (debounced levels), tick_1hz (1 Hz square wave),
//         collision (renderer overlap level).
// Outputs: state, run_en, countdown, seconds, best, game_over.
// Modport slave is the controller; master is the environment that drives
// the switches and tick and consumes the display values.
interface runner_game_ctrl_if
  import runner_pkg::*;
#(
  parameter int SEC_W = DEF_SEC_W
);
  logic               start_sw;
  logic               pause_sw;
  logic               tick_1hz;
  logic               collision;
  logic [STATE_W-1:0] state;
  logic               run_en;
  logic [1:0]         countdown;
  logic [SEC_W-1:0]   seconds;
  logic [SEC_W-1:0]   best;
  logic               game_over;

  modport master (
    output start_sw, pause_sw, tick_1hz, collision,
    input  state, run_en, countdown, seconds, best, game_over
  );

  modport slave (
    input  start_sw, pause_sw, tick_1hz, collision,
    output state, run_en, countdown, seconds, best, game_over
  );
endinterface

// File: rtl/runner_game_ctrl_rise_detect.sv
// One-bit rising-edge detector.
// Ports: clk, reset (async, active high), din (level input), rise (one-cycle
// pulse when din is high and was low on the previous clk).
// The history register resets to RESET_VAL; with 1 a level held high through
// reset does not produce a spurious edge once reset is released.
module rise_detect #(
  parameter bit RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);
  logic prev;

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev <= RESET_VAL;
    else       prev <= din;
  end

  assign rise = din & ~prev;
endmodule

// File: rtl/runner_game_ctrl.sv
// Game-sequencing controller for the runner design.
// Ports: clk, reset (async, active high), bus (slave side of
// runner_game_ctrl_if): switch/tick/collision inputs and the registered
// state, run_en, countdown, seconds, best and game_over outputs.
// Runs the IDLE -> READY -> RUN <-> PAUSED -> OVER sequence, counts elapsed
// run seconds and keeps the best score since reset.
module runner_game_ctrl
  import runner_pkg::*;
#(
  parameter int SEC_W       = DEF_SEC_W,
  parameter int MAX_SECONDS = DEF_MAX_SECONDS,
  parameter int COUNTDOWN   = DEF_COUNTDOWN
) (
  input logic              clk,
  input logic              reset,
  runner_game_ctrl_if.slave bus
);
  localparam logic [SEC_W-1:0] SEC_MAX  = SEC_W'(MAX_SECONDS);
  localparam logic [1:0]       CD_START = 2'(COUNTDOWN);

  logic start_rise, pause_rise, tick_rise;

  rise_detect #(.RESET_VAL(1'b1)) u_start (
    .clk(clk), .reset(reset), .din(bus.start_sw), .rise(start_rise));
  rise_detect #(.RESET_VAL(1'b1)) u_pause (
    .clk(clk), .reset(reset), .din(bus.pause_sw), .rise(pause_rise));
  rise_detect #(.RESET_VAL(1'b1)) u_tick (
    .clk(clk), .reset(reset), .din(bus.tick_1hz), .rise(tick_rise));

  state_e           state_q, state_d;
  logic [1:0]       cd_q, cd_d;
  logic [SEC_W-1:0] sec_q, sec_d, sec_inc;
  logic [SEC_W-1:0] best_q, best_d;
  logic             run_en_q, game_over_q;
  logic             enter_over;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cd_q        <= '0;
      sec_q       <= '0;
      best_q      <= '0;
      run_en_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cd_q        <= cd_d;
      sec_q       <= sec_d;
      best_q      <= best_d;
      // Decoded from the next state so the flags line up with state.
      run_en_q    <= (state_d == RUN);
      game_over_q <= (state_d == OVER);
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    state_d    = state_q;
    cd_d       = cd_q;
    sec_d      = sec_q;
    best_d     = best_q;
    enter_over = 1'b0;
    sec_inc    = sec_q + SEC_W'(1);

    case (state_q)
      IDLE: begin
        sec_d = '0;
        cd_d  = '0;
        if (start_rise) begin
          state_d = READY;
          cd_d    = CD_START;
        end
      end
      READY: begin
        if (start_rise) begin
          state_d = IDLE;
          cd_d    = '0;
        end else if (tick_rise) begin
          if (cd_q > 2'd1) begin
            cd_d = cd_q - 2'd1;
          end else begin
            state_d = RUN;
            cd_d    = '0;
            sec_d   = '0;
          end
        end
      end
      RUN: begin
        // Only the highest-priority event acts in a cycle.
        if (bus.collision) begin
          state_d    = OVER;
          enter_over = 1'b1;
        end else if (pause_rise) begin
          state_d = PAUSED;
        end else if (tick_rise) begin
          sec_d = sec_inc;
          if (sec_inc == SEC_MAX) begin
            state_d    = OVER;
            enter_over = 1'b1;
          end
        end
      end
      PAUSED: begin
        if (start_rise) begin
          state_d = IDLE;
          sec_d   = '0;
        end else if (pause_rise) begin
          state_d = RUN;
        end
      end
      OVER: begin
        if (start_rise) begin
          state_d = IDLE;
          sec_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cd_d    = '0;
        sec_d   = '0;
      end
    endcase

    // Compare against the final value so a win on a tick edge counts.
    if (enter_over && (sec_d > best_q)) best_d = sec_d;
  end

  assign bus.state     = state_q;
  assign bus.run_en    = run_en_q;
  assign bus.countdown = cd_q;
  assign bus.seconds   = sec_q;
  assign bus.best      = best_q;
  assign bus.game_over = game_over_q;
endmodule

// File: doc/runner_game_ctrl.md
Name: runner_game_ctrl

Overview:
Game-sequencing controller for the runner design. Sits between the debounced switches, the 1 Hz tick, the VGA renderer's collision flag and the display path. It owns the game state machine (idle, countdown, run, pause, over) and the elapsed-seconds score and best-score registers. It gates the renderer through run_en and feeds seconds/best to the VGA/7-seg path, replacing the free-running seconds counter.

Parameters:
SEC_W, 8, width of the seconds and best registers
MAX_SECONDS, 99, score at which the run ends as a win; must be < 2**SEC_W
COUNTDOWN, 3, number of tick_1hz rising edges spent in READY before RUN; 1..3

Ports:
clk  input  1  system clock (100 MHz)
reset  input  1  asynchronous, active-high reset (debounced upstream)
start_sw  input  1  debounced start/abort switch, level, synchronous to clk
pause_sw  input  1  debounced pause switch, level, synchronous to clk
tick_1hz  input  1  1 Hz square wave from the clock divider, synchronous to clk
collision  input  1  level from the renderer: player overlaps obstacle
state  output  3  current state encoding (IDLE=0, READY=1, RUN=2, PAUSED=3, OVER=4)
run_en  output  1  high only in RUN; enables obstacle scroll in the renderer
countdown  output  2  remaining countdown value; non-zero only in READY
seconds  output  SEC_W  elapsed run seconds, binary
best  output  SEC_W  best score since reset, binary
game_over  output  1  high only in OVER

Behaviour:
- All outputs registered. Reset (async assert, sync to clk release): state=IDLE, run_en=0, countdown=0, seconds=0, best=0, game_over=0.
- Edge detection: start_rise/pause_rise/tick_rise = input & ~prev, where prev is the input delayed one clk. All prev registers reset to 1, so a level held high through reset produces no edge. An input must fall and rise again to produce an edge.
- A transition takes effect on the clk edge where the rising input is first sampled high. Outputs reflect it one cycle after the input rises.
- IDLE: seconds=0. start_rise -> READY, countdown=COUNTDOWN. pause_rise, tick_rise and collision ignored.
- READY: tick_rise with countdown>1 -> countdown-1. tick_rise with countdown==1 -> RUN, countdown=0, seconds=0. start_rise -> IDLE (abort). Collision and pause ignored.
- RUN: priority collision > pause_rise > tick_rise, and only the highest-priority event acts in a given cycle.
  - collision -> OVER.
  - pause_rise -> PAUSED.
  - tick_rise -> seconds+1; if the new value == MAX_SECONDS, the same edge also moves to OVER.
  - start_rise ignored.
- PAUSED: seconds frozen; ticks and collision ignored. start_rise -> IDLE, seconds cleared; start wins over a simultaneous pause_rise. pause_rise -> RUN.
- OVER: seconds held for display. On the entering edge, best <= seconds_final if seconds_final > best (seconds_final includes a same-edge increment). start_rise -> IDLE, seconds cleared; best retained.
- seconds never exceeds MAX_SECONDS and never wraps. best is cleared only by reset.
- run_en = (state==RUN) and game_over = (state==OVER), both registered together with state.
- Undefined state codes (5-7) -> IDLE on the next clk.
- Reset asserted mid-operation: immediate return to reset values regardless of state, best included.

Decomposition:
- Shared package runner_pkg: state encoding constants (IDLE..OVER), state width 3, default SEC_W, MAX_SECONDS, COUNTDOWN.
- One sub-module: rise_detect. One-bit rising-edge detector with async active-high reset and parameter RESET_VAL (1 here). Instantiated three times: start, pause, tick.
- FSM and score datapath stay in runner_game_ctrl.

Test Plan:
(bench uses COUNTDOWN=3, MAX_SECONDS=5; ticks modelled as short square waves)
- Reset, start_sw 0->1 -> next cycle state=1, countdown=3. Three tick rises -> countdown 2, 1, then state=2, run_en=1, seconds=0, countdown=0.
- In RUN: 4 tick rises -> seconds=4. Assert collision -> state=4, game_over=1, run_en=0, best=4. start rise -> state=0, seconds=0, best=4.
- In RUN at seconds=2: pause rise -> state=3. 3 tick rises -> seconds stays 2. Pause rise -> state=2. 1 tick -> seconds=3.
- 5 ticks in RUN -> seconds=5, state=4 on the 5th tick edge, best=5. Next game, collision at seconds=2 -> best stays 5.
- In RUN at seconds=1, collision + pause rise + tick rise in the same cycle -> state=4, seconds=1, best=1.
- start_sw held high, reset pulsed mid-RUN -> all outputs 0 during reset, state=0 after. No start until start_sw falls and rises, then state=1.
